quiz_judge: RTL and testbench
=============================

QUIZ_JUDGE -- requirements
Module: quiz_judge

Interface
REQ-001 Parameter TIMEOUT, default 50, is the number of answer-window clock cycles, from 1 to 65535.
REQ-002 Parameter MAX_SCORE, default 9, is the winning score, from 1 to 15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port lamp1, input, 1 bit: player-1 lamp from the buzzer block (1 = player 1 buzzed first).
REQ-006 Port lamp2, input, 1 bit: player-2 lamp from the buzzer block.
REQ-007 Port btn_ok, input, 1 bit: host "correct" button, level, already debounced and synchronous to clk.
REQ-008 Port btn_ng, input, 1 bit: host "wrong" button, level, already debounced and synchronous to clk.
REQ-009 Port clear, output, 1 bit: host-clear line to the buzzer block's host-clear input.
REQ-010 Port score1, output, 4 bits: player-1 score, binary.
REQ-011 Port score2, output, 4 bits: player-2 score, binary.
REQ-012 Port answering, output, 2 bits: one-hot answering player (01 = player 1, 10 = player 2, 00 = none).
REQ-013 Port timeout_led, output, 1 bit: the last answer window expired.
REQ-014 Port game_over, output, 1 bit: a player has reached MAX_SCORE.

Function
REQ-015 Button events SHALL be rising edges (btn & ~btn_q), with btn_q a 1-cycle registered copy; an event is acted on in the same cycle it is detected.
REQ-016 The FSM SHALL have four states: WAIT, ANSWER, CLEAR and OVER; all outputs are registered.
REQ-017 WAIT, lamp1=1 and lamp2=0: go to ANSWER, set answering=01, load timer=TIMEOUT-1, clear timeout_led.
REQ-018 WAIT, lamp2=1 and lamp1=0: go to ANSWER with answering=10, same timer load.
REQ-019 WAIT, both lamps high: go to CLEAR with no score change (invalid tie).
REQ-020 WAIT, both lamps low: stay in WAIT.
REQ-021 ANSWER, ok event only: the answering player's score +1; go to OVER if the new score equals MAX_SCORE, else go to CLEAR.
REQ-022 ANSWER, ng event only: the answering player's score -1, saturating at 0; go to CLEAR.
REQ-023 ANSWER, ok and ng events in the same cycle: both are ignored, and the timer keeps running.
REQ-024 ANSWER, no event and timer=0: set timeout_led=1, no score change, go to CLEAR; the window is exactly TIMEOUT cycles long.
REQ-025 ANSWER, an event in the same cycle as timer=0: the event wins, and timeout_led stays 0.
REQ-026 ANSWER, no event and timer≠0: decrement the timer.
REQ-027 On every exit from ANSWER, answering SHALL return to 00.
REQ-028 CLEAR: clear=1 every cycle; return to WAIT in the first cycle both lamps are low; clear is 0 in that WAIT cycle.
REQ-029 Residency in CLEAR SHALL be at least 1 cycle, even if the lamps are already low.
REQ-030 OVER: scores frozen, button events ignored, clear=1 whenever either lamp is high, game_over=1; leave OVER only by reset.
REQ-031 The other player's score SHALL never change on an event.
REQ-032 Scores SHALL never exceed MAX_SCORE and never wrap below 0.

Reset
REQ-033 With rst_n=0 at a clk edge, the block SHALL enter WAIT with score1=0, score2=0, answering=00, clear=0, timeout_led=0, game_over=0, timer=0.
REQ-034 On reset, btn_q SHALL be set to 1, so a button held through reset release gives no event.
REQ-035 Reset asserted in any state, including mid-ANSWER or OVER, SHALL take priority over all other transitions.

Verification
REQ-036 Correct answer: lamp1 rises in WAIT, btn_ok pulses 3 cycles later -> score1=1, then clear=1 until lamp1=0, then WAIT.
REQ-037 Wrong answer at floor: score2=0, player 2 answers, btn_ng pulses -> score2 stays 0, clear pulses, score1 unchanged.
REQ-038 Timeout: TIMEOUT=5, lamp1 rises with no buttons -> after 5 ANSWER cycles timeout_led=1, CLEAR entered; with btn_ok on the 5th cycle instead -> score1 +1, timeout_led=0.
REQ-039 Tie and simultaneous buttons: lamp1=lamp2=1 in WAIT -> CLEAR, no score change; btn_ok and btn_ng on the same edge in ANSWER -> no change, stay in ANSWER.
REQ-040 Game over: MAX_SCORE=2, player 1 correct twice -> game_over=1, score1=2; a later btn_ok is ignored; rst_n=0 -> all outputs back to their reset values.
REQ-041 Held button across reset: btn_ok=1 through reset release with lamp1 high -> no score change until btn_ok falls and rises again.

Source files
------------

// File: rtl/quiz_judge_if.sv
// Quiz judge host-side signal bundle: lamps and buttons in, score/status out.
interface quiz_judge_if;
    localparam int unsigned SCORE_W = 4;

    logic               lamp1;
    logic               lamp2;
    logic               btn_ok;
    logic               btn_ng;
    logic               clear;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [1:0]         answering;
    logic               timeout_led;
    logic               game_over;

    // Host/buzzer side drives lamps and buttons, observes results.
    modport master (
        output lamp1, lamp2, btn_ok, btn_ng,
        input  clear, score1, score2, answering, timeout_led, game_over
    );

    // Judge side.
    modport slave (
        input  lamp1, lamp2, btn_ok, btn_ng,
        output clear, score1, score2, answering, timeout_led, game_over
    );
endinterface

// File: rtl/quiz_judge.sv
// Quiz judge: arbitrates a buzzed player's answer window, keeps scores,
// drives the buzzer host-clear and declares the winner.
module quiz_judge #(
    parameter int unsigned TIMEOUT   = 50,
    parameter int unsigned MAX_SCORE = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    quiz_judge_if.slave jif
);
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned SCORE_W = 4;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ANSWER,
        ST_CLEAR,
        ST_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [1:0]         answering_q, answering_d;
    logic               clear_q, clear_d;
    logic               timeout_led_q, timeout_led_d;
    logic               game_over_q, game_over_d;
    logic               ok_q, ok_d;
    logic               ng_q, ng_d;

    logic               ok_ev;
    logic               ng_ev;
    logic               any_lamp;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] new_score;

    assign ok_ev    = jif.btn_ok & ~ok_q;
    assign ng_ev    = jif.btn_ng & ~ng_q;
    assign any_lamp = jif.lamp1 | jif.lamp2;

    // Next-state, score and output decisions for the current cycle.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        answering_d   = answering_q;
        clear_d       = clear_q;
        timeout_led_d = timeout_led_q;
        game_over_d   = game_over_q;
        ok_d          = jif.btn_ok;
        ng_d          = jif.btn_ng;
        cur_score     = answering_q[1] ? score2_q : score1_q;
        new_score     = cur_score;

        case (state_q)
            ST_WAIT: begin
                clear_d = 1'b0;
                if (jif.lamp1 && jif.lamp2) begin
                    // Tie is invalid: just clear the buzzers.
                    state_d = ST_CLEAR;
                    clear_d = 1'b1;
                end else if (any_lamp) begin
                    state_d       = ST_ANSWER;
                    answering_d   = {jif.lamp2, jif.lamp1};
                    timer_d       = TIMER_LOAD;
                    timeout_led_d = 1'b0;
                end
            end
            ST_ANSWER: begin
                if (ok_ev && !ng_ev) begin
                    new_score   = cur_score + SCORE_W'(1);
                    answering_d = 2'b00;
                    if (new_score == SCORE_MAX) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        clear_d     = any_lamp;
                    end else begin
                        state_d = ST_CLEAR;
                        clear_d = 1'b1;
                    end
                end else if (ng_ev && !ok_ev) begin
                    new_score   = (cur_score == '0) ? '0 : cur_score - SCORE_W'(1);
                    answering_d = 2'b00;
                    state_d     = ST_CLEAR;
                    clear_d     = 1'b1;
                end else if (timer_q == '0) begin
                    timeout_led_d = 1'b1;
                    answering_d   = 2'b00;
                    state_d       = ST_CLEAR;
                    clear_d       = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
                if (answering_q[1]) begin
                    score2_d = new_score;
                end else begin
                    score1_d = new_score;
                end
            end
            ST_CLEAR: begin
                if (!any_lamp) begin
                    state_d = ST_WAIT;
                    clear_d = 1'b0;
                end
            end
            ST_OVER: begin
                clear_d = any_lamp;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State and registered outputs; buttons reset high so a held button gives no event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT;
            timer_q       <= '0;
            score1_q      <= '0;
            score2_q      <= '0;
            answering_q   <= 2'b00;
            clear_q       <= 1'b0;
            timeout_led_q <= 1'b0;
            game_over_q   <= 1'b0;
            ok_q          <= 1'b1;
            ng_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            answering_q   <= answering_d;
            clear_q       <= clear_d;
            timeout_led_q <= timeout_led_d;
            game_over_q   <= game_over_d;
            ok_q          <= ok_d;
            ng_q          <= ng_d;
        end
    end

    assign jif.clear       = clear_q;
    assign jif.score1      = score1_q;
    assign jif.score2      = score2_q;
    assign jif.answering   = answering_q;
    assign jif.timeout_led = timeout_led_q;
    assign jif.game_over   = game_over_q;
endmodule

// File: tb/tb_quiz_judge.sv
// Bench for quiz_judge: directed scenarios plus random play, every cycle's
// outputs checked against a game-level reference model through a queue.
module tb_quiz_judge;
    localparam int unsigned TIMEOUT   = 5;
    localparam int unsigned MAX_SCORE = 3;

    typedef struct packed {
        logic       clear;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] ans;
        logic       tled;
        logic       gover;
    } exp_t;

    logic clk;
    logic rst_n;
    quiz_judge_if qif();

    quiz_judge #(.TIMEOUT(TIMEOUT), .MAX_SCORE(MAX_SCORE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .jif  (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;
    int   cyc      = 0;

    // Reference model: who holds the floor, how many window cycles remain.
    int m_who, m_left, m_s1, m_s2;
    bit m_clearing, m_over, m_tled, m_clear, m_gover, m_pok, m_png;

    function automatic void model_step(input bit r, l1, l2, ok, ng);
        bit ok_e, ng_e;
        int sc;
        if (!r) begin
            m_who = 0; m_left = 0; m_s1 = 0; m_s2 = 0;
            m_clearing = 0; m_over = 0; m_tled = 0; m_clear = 0; m_gover = 0;
            m_pok = 1; m_png = 1;
            return;
        end
        ok_e = ok && !m_pok;
        ng_e = ng && !m_png;
        if (m_over) begin
            m_clear = l1 || l2;
        end else if (m_who != 0) begin
            if (ok_e != ng_e) begin
                sc = (m_who == 1) ? m_s1 : m_s2;
                if (ok_e) sc = sc + 1;
                else if (sc > 0) sc = sc - 1;
                if (m_who == 1) m_s1 = sc; else m_s2 = sc;
                m_who = 0;
                if (ok_e && sc == int'(MAX_SCORE)) begin
                    m_over = 1; m_gover = 1; m_clear = l1 || l2;
                end else begin
                    m_clearing = 1; m_clear = 1;
                end
            end else if (m_left == 1) begin
                m_tled = 1; m_who = 0; m_clearing = 1; m_clear = 1;
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_clearing) begin
            if (!l1 && !l2) begin
                m_clearing = 0; m_clear = 0;
            end
        end else begin
            if (l1 && l2) begin
                m_clearing = 1; m_clear = 1;
            end else if (l1 || l2) begin
                m_who = l1 ? 1 : 2; m_left = int'(TIMEOUT); m_tled = 0;
            end
        end
        m_pok = ok;
        m_png = ng;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.clear = m_clear;
        e.s1    = 4'(m_s1);
        e.s2    = 4'(m_s2);
        e.ans   = (m_who == 1) ? 2'b01 : (m_who == 2) ? 2'b10 : 2'b00;
        e.tled  = m_tled;
        e.gover = m_gover;
        return e;
    endfunction

    // Apply one cycle of inputs and queue the expected post-edge outputs.
    task automatic step(input bit r, input bit l1, input bit l2, input bit ok, input bit ng);
        @(negedge clk);
        rst_n      = r;
        qif.lamp1  = l1;
        qif.lamp2  = l2;
        qif.btn_ok = ok;
        qif.btn_ng = ng;
        model_step(r, l1, l2, ok, ng);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n, input bit l1, input bit l2);
        for (int i = 0; i < n; i++) step(1, l1, l2, 0, 0);
    endtask

    // Monitor: compare DUT outputs after each edge with the queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {qif.clear, qif.score1, qif.score2, qif.answering, qif.timeout_led, qif.game_over};
                n_total++;
                if (a !== e) begin
                    $display("FAIL outputs cyc%0d: got clr=%b s1=%0d s2=%0d ans=%b tled=%b go=%b, exp clr=%b s1=%0d s2=%0d ans=%b tled=%b go=%b",
                             cyc, a.clear, a.s1, a.s2, a.ans, a.tled, a.gover,
                             e.clear, e.s1, e.s2, e.ans, e.tled, e.gover);
                end else begin
                    n_passed++;
                end
            end
        end
    end

    initial begin
        bit l1, l2, ok, ng, r;
        rst_n = 1'b0;
        qif.lamp1 = 1'b0; qif.lamp2 = 1'b0; qif.btn_ok = 1'b0; qif.btn_ng = 1'b0;

        // Reset state.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Correct answer by player 1, ok three cycles after lamp.
        step(1, 1, 0, 0, 0);
        idle(2, 1, 0);
        step(1, 1, 0, 1, 0);
        idle(2, 1, 0);
        idle(2, 0, 0);

        // Wrong answer by player 2 at score floor.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        idle(2, 0, 1);
        idle(2, 0, 0);

        // Timeout with no buttons.
        idle(8, 1, 0);
        idle(2, 0, 0);

        // Ok on the last window cycle wins over timeout.
        idle(5, 1, 0);
        step(1, 1, 0, 1, 0);
        idle(1, 1, 0);
        idle(2, 0, 0);

        // Tie, then simultaneous ok/ng ignored, then a lone ng.
        idle(2, 1, 1);
        idle(2, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 1);
        idle(1, 0, 1);
        step(1, 0, 1, 0, 1);
        idle(1, 0, 1);
        idle(2, 0, 0);

        // Player 1 answers correctly until the game ends, then ok in OVER.
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 0, 0);
            step(1, 1, 0, 1, 0);
            idle(1, 1, 0);
            idle(2, 0, 0);
        end
        step(1, 1, 0, 1, 0);
        idle(2, 0, 0);

        // Button held through reset release gives no event until re-pressed.
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        idle(1, 1, 0);
        idle(2, 0, 0);

        // Random play with occasional resets.
        l1 = 0; l2 = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) l1 = ~l1;
            if ($urandom_range(0, 7) == 0) l2 = ~l2;
            ok = ($urandom_range(0, 3) == 0);
            ng = ($urandom_range(0, 5) == 0);
            step(r, l1, l2, ok, ng);
        end

        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end else begin
            n_passed++;
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
